// File: rtl/jxadc_probe_mux.sv
// rtl/jxadc_probe_mux.sv - routes one bank of a wide probe bus to the JXADC PMOD
// Each bank is shown direct, pulse-stretched, toggle-on-edge or frozen.
module jxadc_probe_mux #(
    parameter int CHANNELS  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int STRETCH   = 4,
    localparam int NUM_BANKS = CHANNELS / OUT_WIDTH,
    localparam int BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int CW        = $clog2(STRETCH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CHANNELS-1:0]  ch,
    input  logic                 cfg_valid,
    input  logic [BW-1:0]        cfg_bank,
    input  logic [1:0]           cfg_mode,
    output logic                 cfg_ack,
    output logic                 cfg_err,
    output logic [OUT_WIDTH-1:0] JXADC
);

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'd0,
        MODE_STRETCH = 2'd1,
        MODE_TOGGLE  = 2'd2,
        MODE_FREEZE  = 2'd3
    } mode_t;

    logic [CHANNELS-1:0]           ch_q, ch_qq, rise;
    logic [BW-1:0]                 bank_r;
    mode_t                         mode_r;
    logic [OUT_WIDTH-1:0][CW-1:0]  cnt, cnt_next;
    logic [OUT_WIDTH-1:0]          tg, tg_next;
    logic [OUT_WIDTH-1:0]          sel, sel_rise, out_next;
    logic                          bank_ok, cfg_load;

    // Edges are detected on the whole bus, so switching banks never fakes an edge.
    assign rise     = ch_q & ~ch_qq;
    assign bank_ok  = 32'(cfg_bank) < NUM_BANKS;
    assign cfg_load = cfg_valid && bank_ok;

    always_comb begin
        sel      = '0;
        sel_rise = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_r == BW'(b)) begin
                sel      = ch_q[b*OUT_WIDTH +: OUT_WIDTH];
                sel_rise = rise[b*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_comb begin
        cnt_next = cnt;
        tg_next  = tg;
        out_next = JXADC;
        case (mode_r)
            MODE_DIRECT: out_next = sel;
            MODE_STRETCH: begin
                for (int i = 0; i < OUT_WIDTH; i++) begin
                    if (sel_rise[i])
                        cnt_next[i] = CW'(STRETCH);
                    else if (cnt[i] != '0)
                        cnt_next[i] = cnt[i] - CW'(1);
                    // Edge cycle plus STRETCH-1 counted cycles gives STRETCH high cycles.
                    out_next[i] = sel_rise[i] | (cnt[i] > CW'(1));
                end
            end
            MODE_TOGGLE: begin
                tg_next  = tg ^ sel_rise;
                out_next = tg_next;
            end
            default: out_next = JXADC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q    <= '0;
            ch_qq   <= '0;
            bank_r  <= '0;
            mode_r  <= MODE_DIRECT;
            cnt     <= '0;
            tg      <= '0;
            JXADC   <= '0;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            ch_q    <= ch;
            ch_qq   <= ch_q;
            JXADC   <= out_next;
            cfg_ack <= cfg_load;
            cfg_err <= cfg_valid && !bank_ok;
            // A config load discards any same-cycle edge for stretch/toggle state.
            if (cfg_load) begin
                bank_r <= cfg_bank;
                mode_r <= mode_t'(cfg_mode);
                cnt    <= '0;
                tg     <= '0;
            end else begin
                cnt <= cnt_next;
                tg  <= tg_next;
            end
        end
    end

endmodule

// File: tb/tb_jxadc_probe_mux.sv
// tb/tb_jxadc_probe_mux.sv - scoreboard bench for jxadc_probe_mux
// Covers the default 4-bank build and a 3-bank build for out-of-range configs.
module tb_jxadc_probe_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] ch = '0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_bank = '0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_ack, cfg_err;
    logic [7:0]  jx;

    logic [23:0] ch3 = '0;
    logic        cfg_valid3 = 1'b0;
    logic [1:0]  cfg_bank3 = '0;
    logic [1:0]  cfg_mode3 = '0;
    logic        cfg_ack3, cfg_err3;
    logic [7:0]  jx3;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    jxadc_probe_mux #(.CHANNELS(32), .OUT_WIDTH(8), .STRETCH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ch(ch), .cfg_valid(cfg_valid),
        .cfg_bank(cfg_bank), .cfg_mode(cfg_mode), .cfg_ack(cfg_ack),
        .cfg_err(cfg_err), .JXADC(jx)
    );

    jxadc_probe_mux #(.CHANNELS(24), .OUT_WIDTH(8), .STRETCH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .ch(ch3), .cfg_valid(cfg_valid3),
        .cfg_bank(cfg_bank3), .cfg_mode(cfg_mode3), .cfg_ack(cfg_ack3),
        .cfg_err(cfg_err3), .JXADC(jx3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [1:0] b, input logic [1:0] m);
        cfg_valid = 1'b1;
        cfg_bank  = b;
        cfg_mode  = m;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_cfg3(input logic [1:0] b, input logic [1:0] m);
        cfg_valid3 = 1'b1;
        cfg_bank3  = b;
        cfg_mode3  = m;
        tick();
        cfg_valid3 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ch    = '1;
        ch3   = '1;
        tick();
        tick();
        checks++;
        if (jx !== 8'h00) begin failures++; $display("FAIL reset_jx got=%h want=00", jx); end
        checks++;
        if ({cfg_ack, cfg_err, jx3} !== 10'h0) begin
            failures++; $display("FAIL reset_flags got=%b%b %h want=00 00", cfg_ack, cfg_err, jx3);
        end
        ch  = '0;
        ch3 = '0;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_direct();
        ch[7:0] = 8'hA5;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (jx !== exp_v) begin failures++; $display("FAIL direct[%0d] got=%h want=%h", i, jx, exp_v); end
        end
    endtask

    task automatic test_cfg_route();
        ch = 32'h003C_0000;
        tick();
        tick();
        do_cfg(2'd2, 2'd0);
        checks++;
        if ({cfg_ack, cfg_err} !== 2'b10) begin
            failures++; $display("FAIL cfg_ack got=%b%b want=10", cfg_ack, cfg_err);
        end
        tick();
        checks++;
        if (cfg_ack !== 1'b0) begin failures++; $display("FAIL cfg_ack_pulse got=%b want=0", cfg_ack); end
        checks++;
        if (jx !== 8'h3C) begin failures++; $display("FAIL cfg_route got=%h want=3C", jx); end
    endtask

    task automatic run_lane_seq(input string name, input logic [8:0] stim, input logic [8:0] expv,
                                input int lane, input int n, input int want_high);
        int highs = 0;
        for (int i = 0; i < n; i++) begin
            ch = '0;
            ch[lane] = stim[i];
            exp_q.push_back(expv[i] ? (8'h01 << lane) : 8'h00);
            tick();
            exp_v = exp_q.pop_front();
            if (jx[lane]) highs++;
            checks++;
            if (jx !== exp_v) begin failures++; $display("FAIL %s[%0d] got=%h want=%h", name, i, jx, exp_v); end
        end
        ch = '0;
        if (want_high >= 0) begin
            checks++;
            if (highs != want_high) begin failures++; $display("FAIL %s_len got=%0d want=%0d", name, highs, want_high); end
        end
    endtask

    task automatic test_stretch();
        ch = '0;
        do_cfg(2'd0, 2'd1);
        tick();
        tick();
        run_lane_seq("stretch1", 9'b0_0000_0001, 9'b0_0001_1110, 1, 8, 4);
        run_lane_seq("stretch2", 9'b0_0000_0101, 9'b0_0111_1110, 1, 9, 6);
    endtask

    task automatic test_toggle();
        ch = '0;
        do_cfg(2'd0, 2'd2);
        checks++;
        if (cfg_ack !== 1'b1) begin failures++; $display("FAIL toggle_ack got=%b want=1", cfg_ack); end
        tick();
        tick();
        run_lane_seq("toggle", 9'b0_0100_1001, 9'b1_1000_1110, 0, 9, -1);
        do_cfg(2'd0, 2'd2);
        tick();
        checks++;
        if (jx !== 8'h00) begin failures++; $display("FAIL toggle_clear got=%h want=00", jx); end
    endtask

    task automatic test_freeze();
        ch = 32'h0000_005A;
        do_cfg(2'd0, 2'd0);
        tick();
        tick();
        checks++;
        if (jx !== 8'h5A) begin failures++; $display("FAIL freeze_pre got=%h want=5A", jx); end
        do_cfg(2'd0, 2'd3);
        for (int i = 0; i < 50; i++) begin
            ch = $urandom;
            exp_q.push_back(8'h5A);
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (jx !== exp_v) begin failures++; $display("FAIL freeze[%0d] got=%h want=%h", i, jx, exp_v); end
        end
        ch = '0;
    endtask

    task automatic test_bad_bank();
        ch3 = 24'h11_77_11;
        do_cfg3(2'd1, 2'd0);
        checks++;
        if ({cfg_ack3, cfg_err3} !== 2'b10) begin
            failures++; $display("FAIL bad_pre_ack got=%b%b want=10", cfg_ack3, cfg_err3);
        end
        tick();
        checks++;
        if (jx3 !== 8'h77) begin failures++; $display("FAIL bad_pre_route got=%h want=77", jx3); end
        do_cfg3(2'd3, 2'd3);
        checks++;
        if ({cfg_ack3, cfg_err3} !== 2'b01) begin
            failures++; $display("FAIL bad_err got=%b%b want=01", cfg_ack3, cfg_err3);
        end
        ch3 = 24'h11_AB_11;
        tick();
        checks++;
        if (cfg_err3 !== 1'b0) begin failures++; $display("FAIL bad_err_pulse got=%b want=0", cfg_err3); end
        tick();
        checks++;
        if (jx3 !== 8'hAB) begin failures++; $display("FAIL bad_route_kept got=%h want=AB", jx3); end
    endtask

    task automatic test_async_reset();
        ch = '0;
        do_cfg(2'd1, 2'd1);
        tick();
        ch = 32'h0000_0200;
        tick();
        ch = '0;
        tick();
        checks++;
        if (jx !== 8'h02) begin failures++; $display("FAIL ar_stretch got=%h want=02", jx); end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({jx, jx3} !== 16'h0) begin failures++; $display("FAIL ar_async got=%h %h want=00 00", jx, jx3); end
        tick();
        rst_n = 1'b1;
        ch = 32'h8100_0081;
        tick();
        tick();
        checks++;
        if (jx !== 8'h81) begin failures++; $display("FAIL ar_bank0_direct got=%h want=81", jx); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_cfg_route();
        test_stretch();
        test_toggle();
        test_freeze();
        test_bad_bank();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
